hub75_bcm_driver: RTL and testbench
===================================

# hub75_bcm_driver

Parametrised HUB75 scan driver: reads pixel pairs from an external frame buffer, shifts them into a 1/SCAN_ROWS-scan RGB panel and displays each row with binary-coded modulation (BCM) of BPP bit planes per colour. It replaces the fixed 1-bit, 16-row, 7-bitmap matrix driver in the panel top level. It adds a frame-coherent double-buffer select and a frame_done strobe for the game logic.

## Interface
- COLS, 64, columns per panel chain (≥2)
- SCAN_ROWS, 16, row pairs scanned; ADDR_W = clog2(SCAN_ROWS) (4 → A..D, 5 → A..E)
- BPP, 4, bits per colour channel (1..8)
- BASE_ON, 8, display cycles for plane 0; plane p shows BASE_ON<<p cycles
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run scanning; sampled at IDLE and at frame end
- buf_sel  in  1  requested frame buffer; sampled only at frame start
- rd_en  out  1  read strobe to frame buffer
- rd_buf  out  1  buffer being read, constant for a whole frame
- rd_row  out  ADDR_W  upper-half row of the read
- rd_col  out  clog2(COLS)  column of the read
- rd_data  in  6*BPP  {r_up,g_up,b_up,r_lo,g_lo,b_lo}, valid the cycle after rd_en
- addr  out  ADDR_W  panel row address (A = bit 0)
- r0,g0,b0,r1,g1,b1  out  1 each  panel serial data, upper/lower half
- sclk  out  1  panel shift clock
- lat  out  1  panel latch
- oe_n  out  1  panel output enable, active low
- frame_done  out  1  one-cycle pulse on last display cycle of a frame

## Operation
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: oe_n=1. When enable=1, go to SHIFT with row=0, plane=0, and capture rd_buf←buf_sel.
- SHIFT: 2-cycle phase per column index k = 0..COLS (k=COLS is tail, no read).
  - Phase 0: rd_en=1 when k<COLS; rd_row=row, rd_col=k; sclk=0.
  - Phase 1: sclk=1 if k≥1, else 0. At the end of phase 1, rgb outputs ← bit `plane` of each rd_data field for column k.
  - So column k data is stable for one full cycle before its rising sclk in phase 1 of k+1.
  - Length: 2*(COLS+1) cycles; oe_n=1 throughout.
- LATCH: 1 cycle; lat=1, oe_n=1, addr←row on entry.
- DISPLAY: oe_n=0 for exactly BASE_ON<<plane cycles, then:
  - plane<BPP-1: plane+1, same row, go to SHIFT.
  - else plane=0; row+1 mod SCAN_ROWS, go to SHIFT.
  - last plane and row=SCAN_ROWS-1: frame_done=1 that cycle. If enable=1, recapture rd_buf and go to SHIFT; else go to IDLE.
- Plane order is LSB first. The previous row remains displayed until the next LATCH.
- enable falling mid-frame has no effect until frame end.
- buf_sel changes mid-frame are ignored until the next frame start.
- Counters: display counter width clog2(BASE_ON<<(BPP-1))+1. Row counter wraps SCAN_ROWS-1→0. Column counter wraps only through the tail index.

## Timing
- Reset values: addr=0, all rgb=0, sclk=0, lat=0, oe_n=1, rd_en=0, rd_buf=0, rd_row=0, rd_col=0, frame_done=0, state=IDLE.
- Reset is honoured mid-operation in any state; outputs return to reset values immediately.
- Enable→first rd_en: 1 cycle (IDLE sees enable, next cycle is SHIFT phase 0).
- Cycles per plane p: 2*(COLS+1) + 1 + (BASE_ON<<p).
- Cycles per frame: SCAN_ROWS * Σp [2*(COLS+1) + 1 + (BASE_ON<<p)].
- All outputs are registered. lat and oe_n=0 never overlap. sclk is never high during LATCH or DISPLAY.

## Structure
- Shared package hub75_pkg holds:
  - state enum (IDLE, SHIFT, LATCH, DISPLAY)
  - rd_data field offsets, as functions of BPP
  - ADDR_W/COL_W derivation functions
- Sub-module hub75_bcm_timer (load BASE_ON<<plane, count down, assert done) owns the DISPLAY window.
- FSM, counters and shift datapath stay in the top module.

## Test plan
All scenarios use COLS=4, SCAN_ROWS=2, BPP=2, BASE_ON=2 unless noted.
- Reset mid-DISPLAY → oe_n=1, addr=0, rgb=0 immediately. After release with enable=1, first rd_en comes 1 cycle later with rd_row=0, rd_col=0.
- rd_data all-ones for row 0, all-zeros for row 1 → 4 sclk rises per plane with r0..b1=1 at each rise for row 0, and 0 for row 1.
- Plane timing → oe_n low for 2 cycles (plane 0) and 4 cycles (plane 1). Frame length 56 cycles. frame_done pulses once per 56 cycles.
- Bit-plane selection: rd_data r_up=2'b10 at all columns → r0=0 during plane 0 shift, r0=1 during plane 1 shift.
- Toggle buf_sel mid-frame → rd_buf unchanged until the cycle after frame_done, then follows buf_sel.
- Drop enable mid-frame → frame completes, frame_done=1, then IDLE with oe_n=1 and no further rd_en. lat/oe_n overlap checked false throughout.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state type, rd_data field layout and sizing helpers for the HUB75 BCM driver
package hub75_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_e;

    function automatic int addr_w(input int scan_rows);
        return (scan_rows > 1) ? $clog2(scan_rows) : 1;
    endfunction

    function automatic int col_w(input int cols);
        return $clog2(cols);
    endfunction

    function automatic int plane_w(input int bpp);
        return (bpp > 1) ? $clog2(bpp) : 1;
    endfunction

    function automatic int cnt_w(input int base_on, input int bpp);
        return $clog2(base_on << (bpp - 1)) + 1;
    endfunction

    // channel 0..5 = r_up, g_up, b_up, r_lo, g_lo, b_lo; r_up sits in the top bits
    function automatic int field_off(input int ch, input int bpp);
        return (5 - ch) * bpp;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: down-counter that times one BCM display window
module hub75_bcm_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done,
    output logic             done_next
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // load the window length, then count down to zero and rest there
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    // count register
    always_ff @(posedge clk or posedge rst) cnt_q <= rst ? '0 : cnt_d;

    // done marks the last cycle of the window; done_next predicts it one cycle early
    assign done      = cnt_q == CNT_W'(1);
    assign done_next = cnt_d == CNT_W'(1);

endmodule

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 scan driver with binary-coded modulation and frame-coherent buffer select
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int COLS      = 64,
    parameter int SCAN_ROWS = 16,
    parameter int BPP       = 4,
    parameter int BASE_ON   = 8,
    localparam int ADDR_W   = addr_w(SCAN_ROWS),
    localparam int COL_W    = col_w(COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              buf_sel,
    output logic              rd_en,
    output logic              rd_buf,
    output logic [ADDR_W-1:0] rd_row,
    output logic [COL_W-1:0]  rd_col,
    input  logic [6*BPP-1:0]  rd_data,
    output logic [ADDR_W-1:0] addr,
    output logic              r0,
    output logic              g0,
    output logic              b0,
    output logic              r1,
    output logic              g1,
    output logic              b1,
    output logic              sclk,
    output logic              lat,
    output logic              oe_n,
    output logic              frame_done
);

    localparam int K_W   = COL_W + 1;
    localparam int PL_W  = plane_w(BPP);
    localparam int CNT_W = cnt_w(BASE_ON, BPP);

    state_e            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              ph_q, ph_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [PL_W-1:0]   plane_q, plane_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_row_q, rd_row_d;
    logic [COL_W-1:0]  rd_col_q, rd_col_d;
    logic [5:0]        rgb_q, rgb_d;
    logic              rd_en_q, rd_en_d, rd_buf_q, rd_buf_d, sclk_q, sclk_d;
    logic              lat_q, lat_d, oe_n_q, oe_n_d, frame_done_q, frame_done_d;
    logic [5:0][BPP-1:0] fields;
    logic              tmr_done, tmr_done_next;
    logic [CNT_W-1:0]  on_cycles;

    assign on_cycles = CNT_W'(BASE_ON << plane_q);

    hub75_bcm_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == LATCH),
        .load_val (on_cycles),
        .done     (tmr_done),
        .done_next(tmr_done_next)
    );

    // scan sequencing: column/phase walk, row and plane advance, frame-boundary buffer capture
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        ph_d     = ph_q;
        row_d    = row_q;
        plane_d  = plane_q;
        rd_buf_d = rd_buf_q;
        case (state_q)
            IDLE: if (enable) begin
                state_d  = SHIFT;
                k_d      = '0;
                ph_d     = 1'b0;
                row_d    = '0;
                plane_d  = '0;
                rd_buf_d = buf_sel;
            end
            SHIFT: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    k_d     = (k_q == K_W'(COLS)) ? '0 : k_q + 1'b1;
                    state_d = (k_q == K_W'(COLS)) ? LATCH : SHIFT;
                end
            end
            LATCH: state_d = DISPLAY;
            DISPLAY: if (tmr_done) begin
                state_d = SHIFT;
                if (plane_q != PL_W'(BPP - 1)) begin
                    plane_d = plane_q + 1'b1;
                end else begin
                    plane_d = '0;
                    row_d   = (row_q == ADDR_W'(SCAN_ROWS - 1)) ? '0 : row_q + 1'b1;
                    if (row_q == ADDR_W'(SCAN_ROWS - 1)) begin
                        rd_buf_d = enable ? buf_sel : rd_buf_q;
                        state_d  = enable ? SHIFT : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are decoded from the next state so every pin comes straight from a flop
    always_comb begin
        fields = '0;
        for (int c = 0; c < 6; c++) fields[c] = rd_data[field_off(c, BPP) +: BPP];
        rd_en_d      = state_d == SHIFT && !ph_d && k_d < K_W'(COLS);
        rd_row_d     = row_d;
        rd_col_d     = k_d[COL_W-1:0];
        sclk_d       = state_d == SHIFT && ph_d && k_d != '0;
        lat_d        = state_d == LATCH;
        oe_n_d       = state_d != DISPLAY;
        addr_d       = lat_d ? row_d : addr_q;
        frame_done_d = state_d == DISPLAY && tmr_done_next && plane_d == PL_W'(BPP - 1)
                       && row_d == ADDR_W'(SCAN_ROWS - 1);
        rgb_d        = (state_q == SHIFT && ph_q && k_q < K_W'(COLS))
                       ? {fields[0][plane_q], fields[1][plane_q], fields[2][plane_q],
                          fields[3][plane_q], fields[4][plane_q], fields[5][plane_q]}
                       : rgb_q;
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            ph_q         <= 1'b0;
            row_q        <= '0;
            plane_q      <= '0;
            addr_q       <= '0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            rgb_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_buf_q     <= 1'b0;
            sclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            ph_q         <= ph_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            addr_q       <= addr_d;
            rd_row_q     <= rd_row_d;
            rd_col_q     <= rd_col_d;
            rgb_q        <= rgb_d;
            rd_en_q      <= rd_en_d;
            rd_buf_q     <= rd_buf_d;
            sclk_q       <= sclk_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_buf     = rd_buf_q;
    assign rd_row     = rd_row_q;
    assign rd_col     = rd_col_q;
    assign addr       = addr_q;
    assign {r0, g0, b0, r1, g1, b1} = rgb_q;
    assign sclk       = sclk_q;
    assign lat        = lat_q;
    assign oe_n       = oe_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: scoreboard bench with a frame-buffer model and a scan-order reference
module tb_hub75_bcm_driver;

    localparam int COLS      = 4;
    localparam int SCAN_ROWS = 2;
    localparam int BPP       = 2;
    localparam int BASE_ON   = 2;
    localparam int FR        = SCAN_ROWS * BPP * COLS;
    localparam int FRAME_CYC = 56;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, buf_sel = 1'b0;
    logic [11:0] rd_data = '0;
    logic        rd_en, rd_buf, sclk, lat, oe_n, frame_done;
    logic        r0, g0, b0, r1, g1, b1;
    logic [0:0]  rd_row, addr;
    logic [1:0]  rd_col;

    hub75_bcm_driver #(.COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .BPP(BPP), .BASE_ON(BASE_ON)) dut (
        .clk(clk), .rst(rst), .enable(enable), .buf_sel(buf_sel),
        .rd_en(rd_en), .rd_buf(rd_buf), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .addr(addr), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .sclk(sclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [11:0] fb [2][SCAN_ROWS][COLS];
    logic [5:0]  exp_q [$];
    logic [5:0]  exp_rgb;
    logic [11:0] pend_word;
    logic        pend, exp_buf, prev_sclk;
    int total = 0, bad = 0;
    int n_reads, n_frames, n_runs, run_len, n_lat, last_fd, cyc, fd_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // the six panel bits shown for one pixel word in bit plane pl: {r0,g0,b0,r1,g1,b1}
    function automatic logic [5:0] plane_bits(input logic [11:0] w, input int pl);
        logic [5:0] b;
        for (int c = 0; c < 6; c++) b[5 - c] = w[(5 - c) * BPP + pl];
        return b;
    endfunction

    task automatic reset_model();
        exp_q.delete();
        pend = 1'b0; prev_sclk = 1'b0;
        n_reads = 0; n_frames = 0; n_runs = 0; run_len = 0; n_lat = 0; last_fd = -1; cyc = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_oe_n"}, oe_n, 1);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_rgb"}, {r0, g0, b0, r1, g1, b1}, 0);
        check({tag, "_sclk"}, sclk, 0);
        check({tag, "_lat"}, lat, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_buf"}, rd_buf, 0);
        check({tag, "_rd_row"}, rd_row, 0);
        check({tag, "_rd_col"}, rd_col, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input bit toggle);
        int target = fd_cnt + n;
        int budget = n * FRAME_CYC + 200;
        while (fd_cnt < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            if (toggle && $urandom_range(0, 6) == 0) buf_sel = 1'($urandom);
        end
        check("frame_wait", fd_cnt >= target, 1);
    endtask

    // frame-buffer model: answers reads one cycle later and predicts each shifted column
    initial begin
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                rd_data = 12'($urandom);
            end else begin
                rd_data = pend ? pend_word : 12'($urandom);
                pend = rd_en;
                if (rd_en) begin
                    int pass, k, row, pl;
                    pass = n_reads / COLS;
                    k    = n_reads % COLS;
                    row  = (pass / BPP) % SCAN_ROWS;
                    pl   = pass % BPP;
                    check("rd_row", rd_row, row);
                    check("rd_col", rd_col, k);
                    check("rd_buf", rd_buf, exp_buf);
                    pend_word = fb[rd_buf][rd_row][rd_col];
                    exp_q.push_back(plane_bits(fb[exp_buf][row][k], pl));
                    n_reads++;
                end
            end
        end
    end

    // panel-side monitor: shifted data, latch address, display windows, frame pacing
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                cyc++;
                check("lat_oe_overlap", int'(lat && !oe_n), 0);
                check("sclk_quiet", int'(sclk && (lat || !oe_n)), 0);
                if (sclk && !prev_sclk) begin
                    if (exp_q.size() == 0) begin
                        check("shift_pending", 0, 1);
                    end else begin
                        exp_rgb = exp_q.pop_front();
                        check("shift_rgb", {r0, g0, b0, r1, g1, b1}, exp_rgb);
                    end
                end
                prev_sclk = sclk;
                if (lat) begin
                    check("latch_addr", addr, (n_lat / BPP) % SCAN_ROWS);
                    n_lat++;
                end
                if (!oe_n) run_len++;
                else if (run_len > 0) begin
                    check("oe_window", run_len, BASE_ON << (n_runs % BPP));
                    n_runs++;
                    run_len = 0;
                end
                if (frame_done) begin
                    n_frames++;
                    fd_cnt++;
                    check("fd_reads", n_reads, n_frames * FR);
                    check("fd_oe", oe_n, 0);
                    if (last_fd >= 0) check("frame_len", cyc - last_fd, FRAME_CYC);
                    last_fd = enable ? cyc : -1;
                    if (enable) exp_buf = buf_sel;
                end
            end
        end
    end

    initial begin
        int bound, viol;
        reset_model();
        exp_buf = 1'b0;
        step(3);
        check_reset("init");
        foreach (fb[b, r, c]) fb[b][r][c] = 12'($urandom);
        buf_sel = 1'b1; exp_buf = 1'b1; enable = 1'b1;
        rst = 1'b0;
        wait_frames(3, 1'b1);

        // reset while the panel is lit, then restart with a row-0-on / row-1-off pattern
        bound = 200;
        do begin @(negedge clk); bound--; end while (oe_n && bound > 0);
        check("reach_display", oe_n, 0);
        #2 rst = 1'b1;
        #1 check_reset("mid");
        reset_model();
        foreach (fb[b, r, c]) fb[b][r][c] = (r == 0) ? 12'hfff : 12'h000;
        buf_sel = 1'b0; exp_buf = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) check("first_rd_en_wait", rd_en, 0);
        @(negedge clk) begin
            check("first_rd_en", rd_en, 1);
            check("first_rd_row", rd_row, 0);
            check("first_rd_col", rd_col, 0);
        end
        wait_frames(1, 1'b0);

        // drop enable mid-frame: the frame finishes, then the driver stays dark and quiet
        step(20);
        enable = 1'b0;
        wait_frames(1, 1'b0);
        viol = 0;
        repeat (60) @(negedge clk) if (rd_en || !oe_n) viol++;
        check("idle_quiet", viol, 0);

        // plane selection: r_up = 2'b10 everywhere, other fields random, buffer toggling
        foreach (fb[b, r, c]) fb[b][r][c] = {2'b10, 10'($urandom)};
        step(1);
        buf_sel = 1'($urandom); exp_buf = buf_sel; enable = 1'b1;
        wait_frames(3, 1'b1);
        enable = 1'b0;
        wait_frames(1, 1'b1);
        step(5);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
